// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter.
//  - ALU select (S) codes, 6 bits wide.
//  - Arbiter FSM state type, exported on the arbiter's dbg_state port.
package alu_pkg;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b100001;
  localparam logic [5:0] ALU_AND  = 6'b011100;
  localparam logic [5:0] ALU_OR   = 6'b011000;
  localparam logic [5:0] ALU_XOR  = 6'b010000;
  localparam logic [5:0] ALU_SLL  = 6'b000100;
  localparam logic [5:0] ALU_SRL  = 6'b010100;
  localparam logic [5:0] ALU_SRA  = 6'b110100;
  localparam logic [5:0] ALU_SLT  = 6'b001000;
  localparam logic [5:0] ALU_SLTU = 6'b001100;
  localparam logic [5:0] ALU_BEQ  = 6'b000011;
  localparam logic [5:0] ALU_BNE  = 6'b000111;
  localparam logic [5:0] ALU_BLT  = 6'b010011;
  localparam logic [5:0] ALU_BGE  = 6'b010111;
  localparam logic [5:0] ALU_BLTU = 6'b011011;
  localparam logic [5:0] ALU_BGEU = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//  A, B : operands
//  S    : operation select (ALU_* codes from alu_pkg)
//  Q    : arithmetic/logic result; 0 for branch compares and unknown codes
//  CMP  : branch-compare outcome; 0 for non-branch and unknown codes
// Shifts use B[4:0] as the shift amount. Arithmetic wraps at 32 bits,
// carry/overflow are not reported.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  S,
  output logic [31:0] Q,
  output logic        CMP
);

  always_comb begin
    Q   = '0;
    CMP = 1'b0;
    case (S)
      ALU_ADD:  Q = A + B;
      ALU_SUB:  Q = A - B;
      ALU_AND:  Q = A & B;
      ALU_OR:   Q = A | B;
      ALU_XOR:  Q = A ^ B;
      ALU_SLL:  Q = A << B[4:0];
      ALU_SRL:  Q = A >> B[4:0];
      ALU_SRA:  Q = $unsigned($signed(A) >>> B[4:0]);
      ALU_SLT:  Q = {31'b0, $signed(A) < $signed(B)};
      ALU_SLTU: Q = {31'b0, A < B};
      ALU_BEQ:  CMP = (A == B);
      ALU_BNE:  CMP = (A != B);
      ALU_BLT:  CMP = ($signed(A) < $signed(B));
      ALU_BGE:  CMP = ($signed(A) >= $signed(B));
      ALU_BLTU: CMP = (A < B);
      ALU_BGEU: CMP = (A >= B);
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
//  clk, rst    : clock, synchronous active-high reset
//  req_valid   : per-requester request
//  req_ready   : per-requester accept strobe (at most one bit set)
//  req_a/req_b : 32-bit operands, requester i at [32*i +: 32]
//  req_s       : 6-bit ALU select, requester i at [6*i +: 6]
//  resp_valid  : one-hot, result belongs to requester i
//  resp_ready  : per-requester result acceptance
//  resp_q/cmp  : registered ALU result of the last completed operation
//  dbg_state   : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is combinational from req_valid while IDLE; a
// requester keeps valid and operands stable until it sees req_ready (or
// withdraws the request, which then has no effect). resp_valid stays high
// with a stable result until resp_ready of the owning requester is high.
//
// Flow: IDLE (grant + latch operands) -> EXEC (ALU evaluates, result
// registered) -> RESP (hold until taken) -> IDLE. One op in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*6-1:0]  req_s,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_q,
  output logic                  resp_cmp,
  output state_t                dbg_state
);

  // First set bit at or after ptr, searching cyclically. The loop runs from
  // the farthest candidate down so the nearest valid one is assigned last.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
      if (v[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_r;
  logic [31:0]    a_r;
  logic [31:0]    b_r;
  logic [5:0]     s_r;

  logic [31:0]    a_arr [NUM_REQ];
  logic [31:0]    b_arr [NUM_REQ];
  logic [5:0]     s_arr [NUM_REQ];

  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;
  logic           any_valid;
  logic [31:0]    alu_q;
  logic           alu_cmp;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[32*i +: 32];
      b_arr[i] = req_b[32*i +: 32];
      s_arr[i] = req_s[6*i +: 6];
    end
  end

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, rr_ptr);
  assign ptr_next  = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // Accept is combinational so the grant lands in the same cycle the
  // operands are latched. Masked during reset: an accept the FSM would drop
  // must not be signalled.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && any_valid && !rst) req_ready[grant] = 1'b1;
  end

  alu u_alu (
    .A   (a_r),
    .B   (b_r),
    .S   (s_r),
    .Q   (alu_q),
    .CMP (alu_cmp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      id_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      s_r        <= '0;
      resp_valid <= '0;
      resp_q     <= '0;
      resp_cmp   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            a_r    <= a_arr[grant];
            b_r    <= b_arr[grant];
            s_r    <= s_arr[grant];
            id_r   <= grant;
            rr_ptr <= ptr_next;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_q     <= alu_q;
          resp_cmp   <= alu_cmp;
          resp_valid <= onehot(id_r);
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's resp_ready matters; resp_q/resp_cmp hold.
          if (resp_ready[id_r]) begin
            resp_valid <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [11:0] req_s;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_q;
  logic        resp_cmp;
  state_t      dbg_state;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(2), .IDW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_q     (resp_q),
    .resp_cmp   (resp_cmp),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    return 2'b01 << i;
  endfunction

  // Drive phase: just after the rising edge. Sample phase: falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_s[6*i +: 6]   = s;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    @(posedge clk);
    @(posedge clk);
    smp();
    check("rst_req_ready",  req_ready,  2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_q",     resp_q,     32'h0);
    check("rst_resp_cmp",   resp_cmp,   1'b0);
    check("rst_state",      dbg_state,  ST_IDLE);
    nxt();
    rst = 1'b0;
  endtask

  // Single requester i issues one op from IDLE; checks grant, latency, result.
  task automatic do_op(input string name, input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] s,
                       input logic [31:0] eq, input logic ecmp);
    set_req(i, a, b, s);
    req_valid  = oh(i);
    resp_ready = 2'b11;
    smp();
    check({name, "_grant"}, req_ready, oh(i));
    nxt();
    req_valid = '0;
    smp();
    check({name, "_exec_noresp"}, resp_valid, 2'b00);
    check({name, "_exec_ready"},  req_ready,  2'b00);
    nxt();
    smp();
    check({name, "_resp_valid"}, resp_valid, oh(i));
    check({name, "_resp_q"},     resp_q,     eq);
    check({name, "_resp_cmp"},   resp_cmp,   ecmp);
    nxt();
    smp();
    check({name, "_back_idle"}, dbg_state,  ST_IDLE);
    check({name, "_cleared"},   resp_valid, 2'b00);
    nxt();
  endtask

  // Reference ALU: returns {cmp, q}.
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] s);
    logic [31:0] q;
    logic        c;
    int          sh;
    q  = 32'h0;
    c  = 1'b0;
    sh = int'(b % 32);
    if      (s == ALU_ADD)  q = a + b;
    else if (s == ALU_SUB)  q = a - b;
    else if (s == ALU_AND)  q = a & b;
    else if (s == ALU_OR)   q = a | b;
    else if (s == ALU_XOR)  q = a ^ b;
    else if (s == ALU_SLL)  q = a << sh;
    else if (s == ALU_SRL)  q = a >> sh;
    else if (s == ALU_SRA)  q = $unsigned($signed(a) >>> sh);
    else if (s == ALU_SLT)  q = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (s == ALU_SLTU) q = (a < b) ? 32'd1 : 32'd0;
    else if (s == ALU_BEQ)  c = (a == b);
    else if (s == ALU_BNE)  c = (a != b);
    else if (s == ALU_BLT)  c = ($signed(a) < $signed(b));
    else if (s == ALU_BGE)  c = !($signed(a) < $signed(b));
    else if (s == ALU_BLTU) c = (a < b);
    else if (s == ALU_BGEU) c = !(a < b);
    return {c, q};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  s;
    logic [31:0] q;
    logic        cmp;
  } vec_t;

  vec_t       vecs [18];
  logic [5:0] codes [16];

  // ---------------- scoreboard (random phase) ----------------
  logic [33:0] exp_q [$];   // {id, cmp, q}
  int          age;
  int          model_ptr;
  logic        pv [2];
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [5:0]  ps [2];

  int          gq [$];
  int          grants;
  int          resps;
  int          g;
  int          idx;
  logic [1:0]  exp_rr;
  logic [1:0]  seen_rr;
  logic [32:0] r;
  logic [33:0] front;

  initial begin
    vecs[0]  = '{32'd3,        32'd3,  ALU_ADD,  32'd6,        1'b0};
    vecs[1]  = '{32'hffffffff, 32'd1,  ALU_ADD,  32'h0,        1'b0};
    vecs[2]  = '{32'd4,        32'd5,  ALU_SUB,  32'hffffffff, 1'b0};
    vecs[3]  = '{32'd6,        32'd5,  ALU_AND,  32'd4,        1'b0};
    vecs[4]  = '{32'hf0,       32'h0f, ALU_OR,   32'hff,       1'b0};
    vecs[5]  = '{32'hff,       32'h0f, ALU_XOR,  32'hf0,       1'b0};
    vecs[6]  = '{32'd1,        32'd31, ALU_SLL,  32'h80000000, 1'b0};
    vecs[7]  = '{32'd1,        32'd33, ALU_SLL,  32'd2,        1'b0};
    vecs[8]  = '{32'h80000000, 32'd4,  ALU_SRL,  32'h08000000, 1'b0};
    vecs[9]  = '{32'hfffffff8, 32'd2,  ALU_SRA,  32'hfffffffe, 1'b0};
    vecs[10] = '{32'hffffffff, 32'd1,  ALU_SLT,  32'd1,        1'b0};
    vecs[11] = '{32'hffffffff, 32'd1,  ALU_SLTU, 32'd0,        1'b0};
    vecs[12] = '{32'd7,        32'd7,  ALU_BEQ,  32'd0,        1'b1};
    vecs[13] = '{32'd7,        32'd7,  ALU_BNE,  32'd0,        1'b0};
    vecs[14] = '{32'hfffffffe, 32'd2,  ALU_BLT,  32'd0,        1'b1};
    vecs[15] = '{32'hfffffffe, 32'd2,  ALU_BGE,  32'd0,        1'b0};
    vecs[16] = '{32'd1,        32'd2,  ALU_BLTU, 32'd0,        1'b1};
    vecs[17] = '{32'd2,        32'd1,  ALU_BGEU, 32'd0,        1'b1};

    codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
              ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

    req_a = '0;
    req_b = '0;
    req_s = '0;

    // 1: req0 alone, ADD 3+3
    do_reset();
    do_op("t1_add", 0, 32'd3, 32'd3, ALU_ADD, 32'd6, 1'b0);

    // 2: both requesters together from reset
    do_reset();
    set_req(0, 32'd4, 32'd5, ALU_SUB);
    set_req(1, 32'hfffffffe, 32'd2, ALU_BLT);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    smp();
    check("t2_grant0", req_ready, 2'b01);
    nxt();
    req_valid = 2'b10;
    smp();
    check("t2_exec_ready", req_ready, 2'b00);
    nxt();
    smp();
    check("t2_resp0_valid", resp_valid, 2'b01);
    check("t2_resp0_q",     resp_q,     32'hffffffff);
    check("t2_resp_ready",  req_ready,  2'b00);
    nxt();
    smp();
    check("t2_grant1", req_ready, 2'b10);
    nxt();
    req_valid = 2'b00;
    nxt();
    smp();
    check("t2_resp1_valid", resp_valid, 2'b10);
    check("t2_resp1_cmp",   resp_cmp,   1'b1);
    nxt();

    // 3: both valid continuously, 8 ops, grants alternate from 0
    do_reset();
    grants = 0;
    resps  = 0;
    gq.delete();
    set_req(0, 32'd10, 32'd0, ALU_ADD);
    set_req(1, 32'd20, 32'd0, ALU_ADD);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int c = 0; c < 80 && resps < 8; c++) begin
      smp();
      seen_rr = req_ready;
      if (seen_rr != 2'b00) begin
        check("t3_grant_order", seen_rr, oh(grants % 2));
        gq.push_back(grants % 2);
        grants++;
      end
      if (resp_valid != 2'b00) begin
        if (gq.size() == 0) check("t3_resp_unexpected", resp_valid, 2'b00);
        else                check("t3_resp_owner", resp_valid, oh(gq.pop_front()));
        resps++;
      end
      nxt();
      // fresh operands for whoever was just accepted; valid stays high
      for (int i = 0; i < 2; i++)
        if (seen_rr[i]) set_req(i, 32'(100 * i + grants), 32'd1, ALU_ADD);
    end
    check("t3_resp_count", 64'(resps), 64'd8);
    req_valid = 2'b00;

    // 4: backpressure on requester 0 for 5 cycles, requester 1 waiting
    do_reset();
    resp_ready = 2'b10;
    set_req(0, 32'd6, 32'd5, ALU_AND);
    req_valid = 2'b01;
    smp();
    check("t4_grant0", req_ready, 2'b01);
    nxt();
    set_req(1, 32'd1, 32'd2, ALU_ADD);
    req_valid = 2'b10;
    smp();
    check("t4_exec_ready", req_ready, 2'b00);
    check("t4_exec_state", dbg_state, ST_EXEC);
    for (int k = 0; k < 5; k++) begin
      nxt();
      smp();
      check("t4_hold_valid", resp_valid, 2'b01);
      check("t4_hold_q",     resp_q,     32'd4);
      check("t4_hold_ready", req_ready,  2'b00);
    end
    nxt();
    resp_ready = 2'b01;
    smp();
    check("t4_take_valid", resp_valid, 2'b01);
    nxt();
    resp_ready = 2'b11;
    smp();
    check("t4_idle_state", dbg_state,  ST_IDLE);
    check("t4_idle_valid", resp_valid, 2'b00);
    check("t4_idle_q",     resp_q,     32'd4);
    check("t4_idle_grant", req_ready,  2'b10);
    nxt();
    req_valid = 2'b00;

    // 5: reset during EXEC aborts the op; arbitration restarts at req0
    do_reset();
    do_op("t5_pre", 0, 32'd3, 32'd3, ALU_ADD, 32'd6, 1'b0);
    set_req(0, 32'hfffffff8, 32'd2, ALU_SRA);
    req_valid = 2'b01;
    smp();
    check("t5_grant", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    rst       = 1'b1;
    smp();
    check("t5_in_exec", dbg_state, ST_EXEC);
    nxt();
    rst = 1'b0;
    smp();
    check("t5_resp_valid", resp_valid, 2'b00);
    check("t5_resp_q",     resp_q,     32'h0);
    check("t5_resp_cmp",   resp_cmp,   1'b0);
    check("t5_req_ready",  req_ready,  2'b00);
    check("t5_state",      dbg_state,  ST_IDLE);
    nxt();
    smp();
    check("t5_no_late_resp", resp_valid, 2'b00);
    nxt();
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    req_valid = 2'b11;
    smp();
    check("t5_rearb_req0", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;

    // 6: requester 1 alone
    do_reset();
    do_op("t6_bgeu", 1, 32'd5, 32'd5, ALU_BGEU, 32'd0, 1'b1);
    do_op("t6_sltu", 1, 32'hfffffffe, 32'd2, ALU_SLTU, 32'd0, 1'b0);

    // table: every S code, alternating requesters
    for (int k = 0; k < 18; k++)
      do_op($sformatf("vec%0d", k), k % 2, vecs[k].a, vecs[k].b, vecs[k].s,
            vecs[k].q, vecs[k].cmp);

    // random traffic against a transaction-level model
    do_reset();
    model_ptr = 0;
    exp_q.delete();
    age = 0;
    for (int i = 0; i < 2; i++) pv[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
          ps[i] = codes[$urandom_range(0, 15)];
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
        req_valid[i] = pv[i];
        set_req(i, pa[i], pb[i], ps[i]);
      end
      resp_ready = 2'($urandom_range(0, 3));
      smp();

      exp_rr = 2'b00;
      g = -1;
      if (exp_q.size() == 0) begin
        for (int k = 0; k < 2; k++) begin
          idx = (model_ptr + k) % 2;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0) exp_rr = oh(g);
      end
      check("rnd_req_ready", req_ready, exp_rr);

      if (exp_q.size() != 0 && age >= 2) begin
        front = exp_q[0];
        check("rnd_resp_valid", resp_valid, oh(int'(front[33])));
        check("rnd_resp_q",     resp_q,     front[31:0]);
        check("rnd_resp_cmp",   resp_cmp,   front[32]);
      end else begin
        check("rnd_resp_idle", resp_valid, 2'b00);
      end

      if (exp_q.size() != 0) begin
        front = exp_q[0];
        if (age >= 2 && resp_ready[front[33]]) void'(exp_q.pop_front());
        else age++;
      end
      if (g >= 0) begin
        r = alu_ref(pa[g], pb[g], ps[g]);
        exp_q.push_back({g[0], r});
        age       = 1;
        model_ptr = (g + 1) % 2;
      end
      for (int i = 0; i < 2; i++)
        if (req_ready[i]) pv[i] = 1'b0;
      nxt();
    end
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
